// File: rtl/drp_arbiter.sv
// drp_arbiter: shares one QPLL/GT-common DRP port between two requesters.
// Port A is the PCIe QPLL rate-change controller and port B is the software
// DRP master. Requests are latched, served round-robin one at a time, and a
// missing DRP_RDY is bounded by a timeout.
//
// Handshake (both requester ports and the shared port): EN is a one-cycle
// request strobe that carries ADDR/WE/DI in the same cycle; RDY is a one-cycle
// completion pulse that carries DO in the same cycle. Exactly one RDY answers
// each accepted EN. WE is meaningful only while EN is high.
module drp_arbiter #(
  parameter int              AW      = 8,
  parameter int              DW      = 16,
  parameter int              TIMEOUT = 1023,
  parameter logic [DW-1:0]   TO_DATA = 16'hDEAD
) (
  input  logic          DRP_CLK,
  input  logic          DRP_RST,
  // requester A
  input  logic [AW-1:0] A_ADDR,
  input  logic          A_EN,
  input  logic          A_WE,
  input  logic [DW-1:0] A_DI,
  output logic [DW-1:0] A_DO,
  output logic          A_RDY,
  // requester B
  input  logic [AW-1:0] B_ADDR,
  input  logic          B_EN,
  input  logic          B_WE,
  input  logic [DW-1:0] B_DI,
  output logic [DW-1:0] B_DO,
  output logic          B_RDY,
  // shared DRP master
  output logic [AW-1:0] DRP_ADDR,
  output logic          DRP_EN,
  output logic          DRP_WE,
  output logic [DW-1:0] DRP_DI,
  input  logic [DW-1:0] DRP_DO,
  input  logic          DRP_RDY,
  // status
  output logic          BUSY,
  output logic [3:0]    STATUS,
  input  logic          STATUS_CLR,
  // FSM state for observation (0 idle, 1 issue, 2 wait)
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Last WAIT count value before the transaction is declared lost.
  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  logic          gnt_b;      // port owning the transaction in flight (1 = B)
  logic          last_b;     // last granted port (1 = B)
  logic [15:0]   tcnt;

  logic          pend_a;
  logic [AW-1:0] a_addr_q;
  logic          a_we_q;
  logic [DW-1:0] a_di_q;

  logic          pend_b;
  logic [AW-1:0] b_addr_q;
  logic          b_we_q;
  logic [DW-1:0] b_di_q;

  logic          req_a;
  logic          req_b;
  logic          grant;
  logic          grant_b;
  logic          a_take;
  logic          b_take;
  logic          cpl;
  logic [DW-1:0] cpl_data;
  logic [3:0]    st_set;

  // Arbitration, request acceptance, completion and status-set decode.
  always_comb begin
    req_a    = 1'b0;
    req_b    = 1'b0;
    grant    = 1'b0;
    grant_b  = 1'b0;
    a_take   = 1'b0;
    b_take   = 1'b0;
    cpl      = 1'b0;
    cpl_data = DRP_DO;
    st_set   = 4'b0000;

    // A pending flag whose RDY is on the wire this cycle is already served.
    req_a   = pend_a & ~A_RDY;
    req_b   = pend_b & ~B_RDY;
    grant   = (state == S_IDLE) & (req_a | req_b);
    // On contention, the port that was not granted last wins.
    grant_b = req_b & (~req_a | ~last_b);

    // A new strobe is accepted when the slot is free or being freed now.
    a_take  = A_EN & (~pend_a | A_RDY);
    b_take  = B_EN & (~pend_b | B_RDY);

    cpl      = (state == S_WAIT) & (DRP_RDY | (tcnt == TCNT_LAST));
    cpl_data = DRP_RDY ? DRP_DO : TO_DATA;

    st_set[0] = (state == S_WAIT) & ~DRP_RDY & (tcnt == TCNT_LAST);
    st_set[1] = DRP_RDY & (state != S_WAIT);
    st_set[2] = A_EN & ~a_take;
    st_set[3] = B_EN & ~b_take;
  end

  assign BUSY      = (state != S_IDLE) | pend_a | pend_b;
  assign dbg_state = state;

  // Request latches, transaction FSM, shared-port drive and sticky status.
  always_ff @(posedge DRP_CLK or posedge DRP_RST) begin
    if (DRP_RST) begin
      state    <= S_IDLE;
      gnt_b    <= 1'b0;
      last_b   <= 1'b1;
      tcnt     <= '0;
      pend_a   <= 1'b0;
      a_addr_q <= '0;
      a_we_q   <= 1'b0;
      a_di_q   <= '0;
      pend_b   <= 1'b0;
      b_addr_q <= '0;
      b_we_q   <= 1'b0;
      b_di_q   <= '0;
      A_DO     <= '0;
      A_RDY    <= 1'b0;
      B_DO     <= '0;
      B_RDY    <= 1'b0;
      DRP_ADDR <= '0;
      DRP_EN   <= 1'b0;
      DRP_WE   <= 1'b0;
      DRP_DI   <= '0;
      STATUS   <= 4'b0000;
    end else begin
      if (STATUS_CLR) begin
        STATUS <= 4'b0000;
      end else begin
        STATUS <= STATUS | st_set;
      end

      if (a_take) begin
        pend_a   <= 1'b1;
        a_addr_q <= A_ADDR;
        a_we_q   <= A_WE;
        a_di_q   <= A_DI;
      end else if (A_RDY) begin
        pend_a   <= 1'b0;
      end

      if (b_take) begin
        pend_b   <= 1'b1;
        b_addr_q <= B_ADDR;
        b_we_q   <= B_WE;
        b_di_q   <= B_DI;
      end else if (B_RDY) begin
        pend_b   <= 1'b0;
      end

      A_RDY <= 1'b0;
      B_RDY <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant) begin
            state    <= S_ISSUE;
            gnt_b    <= grant_b;
            last_b   <= grant_b;
            DRP_EN   <= 1'b1;
            DRP_WE   <= grant_b ? b_we_q   : a_we_q;
            DRP_ADDR <= grant_b ? b_addr_q : a_addr_q;
            DRP_DI   <= grant_b ? b_di_q   : a_di_q;
          end
        end
        S_ISSUE: begin
          state  <= S_WAIT;
          DRP_EN <= 1'b0;
          DRP_WE <= 1'b0;
          tcnt   <= '0;
        end
        S_WAIT: begin
          if (cpl) begin
            state <= S_IDLE;
            if (gnt_b) begin
              B_DO  <= cpl_data;
              B_RDY <= 1'b1;
            end else begin
              A_DO  <= cpl_data;
              A_RDY <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
